eve_chain_rr_arbiter: RTL and testbench

//   Shares one transfer-event output stream between CHAIN_NUM per-chain event sources.

---
 rtl/eve_chain_rr_arbiter.sv | 115 +++++++++++
 tb/tb_eve_chain_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eve_chain_rr_arbiter.sv
// Round-robin merge of CHAIN_NUM per-chain event streams into one registered
// output stage. Events addressed to disconnected channels are consumed and
// counted instead of forwarded.
module eve_chain_rr_arbiter #(
    parameter int CHAIN_NUM    = 4,
    parameter int CH_PER_CHAIN = 8,
    parameter int CH_NUM       = 32
) (
    input  logic                     user_clk,
    input  logic                     reset_n,
    input  logic [CHAIN_NUM-1:0]     s_axis_eve_tvalid,
    input  logic [CHAIN_NUM*128-1:0] s_axis_eve_tdata,
    output logic [CHAIN_NUM-1:0]     s_axis_eve_tready,
    output logic                     m_axis_eve_tvalid,
    output logic [127:0]             m_axis_eve_tdata,
    output logic [2:0]               m_axis_eve_tuser,
    input  logic                     m_axis_eve_tready,
    input  logic [CH_NUM-1:0]        dma_ch_connection_enable,
    output logic [15:0]              eve_drop_cnt
);

    localparam int PW = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1;
    localparam int LW = (CH_PER_CHAIN > 1) ? $clog2(CH_PER_CHAIN) : 1;
    localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [PW-1:0] PTR_INIT = PW'(CHAIN_NUM - 1);

    logic          m_tvalid_q, m_tvalid_d;
    logic [127:0]  m_tdata_q, m_tdata_d;
    logic [2:0]    m_tuser_q, m_tuser_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] last_grant_q, last_grant_d;

    logic          out_free;
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [127:0]  win_data;
    logic [GW-1:0] win_gch;
    logic          win_connected;
    logic          accept;
    int unsigned   cand;
    int unsigned   local_ch;

    // Round-robin search starting just after the last granted chain
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= CHAIN_NUM; i++) begin
            cand = 32'(last_grant_q) + i;
            if (cand >= 32'(CHAIN_NUM)) cand = cand - 32'(CHAIN_NUM);
            if (!win_found && s_axis_eve_tvalid[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    // Winner payload, global channel lookup and output-stage availability
    always_comb begin
        win_data      = s_axis_eve_tdata[32'(win_idx)*128 +: 128];
        local_ch      = 32'(win_data[LW-1:0]) & 32'(CH_PER_CHAIN - 1);
        win_gch       = GW'(32'(win_idx) * 32'(CH_PER_CHAIN) + local_ch);
        win_connected = dma_ch_connection_enable[win_gch];
        out_free      = !m_tvalid_q || m_axis_eve_tready;
        accept        = out_free && win_found;
    end

    // One-hot accept to the winner; held low while reset is asserted
    always_comb begin
        s_axis_eve_tready = '0;
        if (accept && reset_n) s_axis_eve_tready[win_idx] = 1'b1;
    end

    // Next state: drain held event, load or drop the accepted one
    always_comb begin
        m_tvalid_d   = m_tvalid_q && !m_axis_eve_tready;
        m_tdata_d    = m_tdata_q;
        m_tuser_d    = m_tuser_q;
        drop_cnt_d   = drop_cnt_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = win_idx;
            if (win_connected) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = win_data;
                m_tuser_d  = 3'(win_idx);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // State registers
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tuser_q    <= '0;
            drop_cnt_q   <= '0;
            last_grant_q <= PTR_INIT;
        end else begin
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
            drop_cnt_q   <= drop_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m_axis_eve_tvalid = m_tvalid_q;
    assign m_axis_eve_tdata  = m_tdata_q;
    assign m_axis_eve_tuser  = m_tuser_q;
    assign eve_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_eve_chain_rr_arbiter.sv
// Scoreboard bench for eve_chain_rr_arbiter: a driver process issues events
// from per-chain source queues and predicts grants; a monitor process checks
// the output stage against the expected-event queue.
module tb_eve_chain_rr_arbiter;

    localparam int N   = 4;
    localparam int CPC = 8;
    localparam int CHN = 32;
    localparam int LW  = 3;

    logic               user_clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       s_axis_eve_tvalid;
    logic [N*128-1:0]   s_axis_eve_tdata;
    logic [N-1:0]       s_axis_eve_tready;
    logic               m_axis_eve_tvalid;
    logic [127:0]       m_axis_eve_tdata;
    logic [2:0]         m_axis_eve_tuser;
    logic               m_axis_eve_tready;
    logic [CHN-1:0]     dma_ch_connection_enable;
    logic [15:0]        eve_drop_cnt;

    eve_chain_rr_arbiter #(.CHAIN_NUM(N), .CH_PER_CHAIN(CPC), .CH_NUM(CHN)) dut (
        .user_clk                 (user_clk),
        .reset_n                  (reset_n),
        .s_axis_eve_tvalid        (s_axis_eve_tvalid),
        .s_axis_eve_tdata         (s_axis_eve_tdata),
        .s_axis_eve_tready        (s_axis_eve_tready),
        .m_axis_eve_tvalid        (m_axis_eve_tvalid),
        .m_axis_eve_tdata         (m_axis_eve_tdata),
        .m_axis_eve_tuser         (m_axis_eve_tuser),
        .m_axis_eve_tready        (m_axis_eve_tready),
        .dma_ch_connection_enable (dma_ch_connection_enable),
        .eve_drop_cnt             (eve_drop_cnt)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [127:0] d;
        int           u;
    } ev_t;

    int unsigned  checks = 0;
    int unsigned  passed = 0;
    logic [127:0] src_q [N][$];
    ev_t          exp_q[$];
    int           obs_u[$];
    int           rr;
    bit           held;
    int           drops;
    bit           mon_en;
    bit           en_rand;
    int           rdy_pct;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N; c++) src_q[c].delete();
        exp_q.delete();
        obs_u.delete();
        rr    = N - 1;
        held  = 1'b0;
        drops = 0;
    endtask

    // One clock of stimulus plus grant prediction from the arbitration rules
    task automatic cycle();
        int           w;
        bit           fr;
        bit           nh;
        int           nd;
        int           c;
        logic [127:0] d;
        logic [N-1:0] er;
        int unsigned  g;
        @(negedge user_clk);
        if (en_rand)
            for (int i = 0; i < CHN; i++) dma_ch_connection_enable[i] = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < N; i++) begin
            s_axis_eve_tvalid[i] = (src_q[i].size() > 0);
            s_axis_eve_tdata[i*128 +: 128] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        m_axis_eve_tready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        fr = !held || m_axis_eve_tready;
        w  = -1;
        if (fr)
            for (int k = 1; k <= N; k++) begin
                c = (rr + k) % N;
                if (w < 0 && s_axis_eve_tvalid[c]) w = c;
            end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("s_tready", s_axis_eve_tready, er);
        nh = held && !m_axis_eve_tready;
        nd = drops;
        if (w >= 0) begin
            d = src_q[w].pop_front();
            g = w * CPC + int'(d[LW-1:0]);
            if (dma_ch_connection_enable[g]) begin
                exp_q.push_back('{d: d, u: w});
                nh = 1'b1;
            end else if (nd < 65535) nd++;
            rr = w;
        end
        @(posedge user_clk);
        held  = nh;
        drops = nd;
    endtask

    // Output monitor: valid/drop state every cycle, held payload against scoreboard
    always @(negedge user_clk) begin
        #3;
        if (mon_en) begin
            chk("m_tvalid", m_axis_eve_tvalid, held);
            chk("drop_cnt", eve_drop_cnt, drops);
            if (held) begin
                if (exp_q.size() == 0) chk("exp_empty", 1, 0);
                else begin
                    chk("m_tdata", m_axis_eve_tdata, exp_q[0].d);
                    chk("m_tuser", m_axis_eve_tuser, exp_q[0].u);
                    if (m_axis_eve_tready) begin
                        obs_u.push_back(exp_q[0].u);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge user_clk);
        mon_en = 1'b0;
        reset_n = 1'b0;
        s_axis_eve_tvalid = '0;
        m_axis_eve_tready = 1'b0;
        model_clear();
        repeat (2) @(negedge user_clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int           exp_ord [6] = '{0, 1, 2, 3, 0, 1};
    logic [127:0] dd;

    initial begin
        reset_n = 1'b0;
        mon_en = 1'b0;
        en_rand = 1'b0;
        rdy_pct = 100;
        s_axis_eve_tvalid = '1;
        s_axis_eve_tdata = '0;
        m_axis_eve_tready = 1'b1;
        dma_ch_connection_enable = '1;
        model_clear();

        // Reset values, with all chains requesting during reset
        repeat (3) @(negedge user_clk);
        #1;
        chk("rst_tready", s_axis_eve_tready, 0);
        chk("rst_tvalid", m_axis_eve_tvalid, 0);
        chk("rst_tdata", m_axis_eve_tdata, 0);
        chk("rst_tuser", m_axis_eve_tuser, 0);
        chk("rst_drop", eve_drop_cnt, 0);
        s_axis_eve_tvalid = '0;
        @(negedge user_clk);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // Chain 2 alone, four back-to-back events
        for (int i = 0; i < 4; i++) src_q[2].push_back(rnd128());
        run(6);
        chk("c2_count", obs_u.size(), 4);
        for (int i = 0; i < obs_u.size(); i++) chk("c2_tuser", obs_u[i], 2);

        // All chains requesting after reset: grant order from chain 0
        do_reset();
        for (int c = 0; c < N; c++) repeat (2) src_q[c].push_back(rnd128());
        run(11);
        for (int i = 0; i < 6; i++)
            chk("rr_order", (i < obs_u.size()) ? obs_u[i] : 99, exp_ord[i]);

        // Backpressure for 5 cycles with an event held, then release
        for (int c = 0; c < N; c++) repeat (3) src_q[c].push_back(rnd128());
        rdy_pct = 100; run(2);
        rdy_pct = 0;   run(5);
        rdy_pct = 100; run(12);

        // Disconnected channel 9 (chain 1, local 1) then connected local 2
        do_reset();
        dma_ch_connection_enable = '1;
        dma_ch_connection_enable[9] = 1'b0;
        dd = rnd128(); dd[2:0] = 3'd1; src_q[1].push_back(dd);
        dd = rnd128(); dd[2:0] = 3'd2; src_q[1].push_back(dd);
        run(4);
        chk("drop_one", eve_drop_cnt, 1);
        chk("fwd_count", obs_u.size(), 1);
        chk("fwd_tuser", (obs_u.size() > 0) ? obs_u[0] : 99, 1);

        // Randomized traffic, backpressure and connection enables
        en_rand = 1'b1;
        rdy_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 2) == 0 && src_q[c].size() < 4) src_q[c].push_back(rnd128());
            cycle();
        end
        en_rand = 1'b0;
        dma_ch_connection_enable = '1;

        // Reset while an event is held under backpressure
        for (int c = 0; c < N; c++) src_q[c].delete();
        rdy_pct = 100; run(6);
        src_q[3].push_back(rnd128());
        rdy_pct = 0; run(3);
        @(negedge user_clk);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_tvalid", m_axis_eve_tvalid, 0);
        chk("async_drop", eve_drop_cnt, 0);
        model_clear();
        s_axis_eve_tvalid = '0;
        @(negedge user_clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < N; c++) src_q[c].push_back(rnd128());
        rdy_pct = 100; run(7);
        chk("post_rst_first", (obs_u.size() > 0) ? obs_u[0] : 99, 0);

        // Drop counter saturation
        do_reset();
        dma_ch_connection_enable = '1;
        dma_ch_connection_enable[8] = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            if (src_q[1].size() == 0) begin
                dd = rnd128(); dd[2:0] = 3'd0; src_q[1].push_back(dd);
            end
            cycle();
        end
        run(2);
        chk("drop_sat", eve_drop_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
